// File: rtl/jeff_tdm_demux_if.sv
// Beat stream into the TDM demultiplexer and the frame/status signals coming out of it.
interface jeff_tdm_demux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SLOT_W = $clog2(CHANNELS);

  logic                      in_valid;
  logic                      in_sync;
  logic [WIDTH-1:0]          in_data;
  logic [WIDTH*CHANNELS-1:0] y;
  logic                      frame_valid;
  logic                      sync_err;
  logic                      locked;
  logic [SLOT_W-1:0]         slot;

  modport master (
    output in_valid, in_sync, in_data,
    input  y, frame_valid, sync_err, locked, slot
  );

  modport slave (
    input  in_valid, in_sync, in_data,
    output y, frame_valid, sync_err, locked, slot
  );
endinterface

// File: rtl/jeff_tdm_demux.sv
// TDM demultiplexer: aligns to the slot-0 sync flag, stages one beat per slot and
// presents a whole frame on y with a one-cycle frame_valid strobe.
module jeff_tdm_demux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  jeff_tdm_demux_if.slave   bus
);
  localparam int SLOT_W = $clog2(CHANNELS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]          stage_q [CHANNELS];
  logic [WIDTH-1:0]          stage_d [CHANNELS];
  logic [WIDTH*CHANNELS-1:0] y_q, y_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      sync_err_q, sync_err_d;
  logic                      accept;

  assign accept = en & bus.in_valid;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    slot_d        = slot_q;
    stage_d       = stage_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (bus.in_sync) begin
            stage_d[0] = bus.in_data;
            slot_d     = SLOT_W'(1);
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.in_sync) begin
            // Early sync abandons the partial frame and restarts at slot 0.
            sync_err_d = (slot_q != '0);
            stage_d[0] = bus.in_data;
            slot_d     = SLOT_W'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            stage_d[slot_q] = bus.in_data;
            if (slot_q == LAST_SLOT) begin
              for (int k = 0; k < CHANNELS - 1; k++) begin
                y_d[k*WIDTH +: WIDTH] = stage_q[k];
              end
              y_d[(CHANNELS-1)*WIDTH +: WIDTH] = bus.in_data;
              frame_valid_d = 1'b1;
              slot_d        = '0;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the staging array is
  // reset too so a mid-frame reset cannot leak stale channel data into a later frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      stage_q       <= stage_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.slot        = slot_q;
endmodule

// File: doc/jeff_tdm_demux.md
Name: jeff_tdm_demux

Overview:
Time-division demultiplexer: the receiving end of a muxed 4-bit stream, such as the one built from a 74x157-style 2:1 selector sequenced by a slot counter. It accepts one data beat per valid cycle, uses a sync flag marking slot 0 to align to the frame, and steers each beat into a per-channel staging register. When a full frame has been collected, all channels are presented together on a parallel output bus with a one-cycle frame strobe. Framing errors are detected and reported.

Parameters:
WIDTH, 4, bits per channel/beat
CHANNELS, 4, slots per frame (must be >= 2)
SLOT_W, $clog2(CHANNELS), width of slot index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; when 0 all inputs are ignored and all state is held
in_valid  input  1  a beat is present on in_data this cycle
in_sync  input  1  qualifies the current beat as slot 0; meaningful only when in_valid=1
in_data  input  WIDTH  beat data
y  output  WIDTH*CHANNELS  frame output; channel k occupies y[k*WIDTH +: WIDTH]
frame_valid  output  1  one-cycle pulse when y has just been updated
sync_err  output  1  one-cycle pulse on a framing error
locked  output  1  1 while the state machine is in LOCKED
slot  output  SLOT_W  index of the next expected slot

Behaviour:
- Reset (rst_n=0, asynchronous): y=0, frame_valid=0, sync_err=0, locked=0, slot=0, state=HUNT, staging registers=0. Reset mid-frame discards the partial frame. The first frame after reset requires a fresh sync.
- Only a cycle with en=1 and in_valid=1 is an "accepted beat". All other cycles hold the state. frame_valid and sync_err return to 0 on every cycle in which they are not newly asserted, including cycles with en=0.
- State HUNT:
  - Beats without sync are dropped.
  - A beat with sync: stage[0]<=in_data, slot<=1, state<=LOCKED.
- State LOCKED, beat without sync, slot=s, s != 0:
  - stage[s]<=in_data.
  - If s < CHANNELS-1: slot<=s+1.
  - If s = CHANNELS-1: slot<=0, state stays LOCKED, and the frame completes.
- State LOCKED, slot=0, beat with sync: stage[0]<=in_data, slot<=1. This is the normal back-to-back frame case.
- State LOCKED, slot=0, beat without sync (missing sync):
  - sync_err<=1, state<=HUNT, slot<=0, beat dropped.
- State LOCKED, slot != 0, beat with sync (early sync):
  - sync_err<=1. The partial frame is discarded; no frame_valid is issued for it.
  - This beat restarts a frame: stage[0]<=in_data, slot<=1, state stays LOCKED.
- Frame completion:
  - On the clock edge that accepts slot CHANNELS-1, y is loaded with all stages, using in_data for the last channel.
  - frame_valid=1 for exactly that following cycle. Latency from the last beat to y/frame_valid is 1 clock.
  - y holds its value until the next completed frame. Errors and HUNT never clear y.
- locked = (state==LOCKED). slot mirrors the internal counter.
- Counter wrap: slot never exceeds CHANNELS-1. For non-power-of-2 CHANNELS, the counter explicitly wraps to 0.
- en=0 mid-frame suspends the frame; it resumes at the same slot when en=1.

Test Plan (CHANNELS=4, WIDTH=4):
1. Reset, then accepted beats sync/A,5,3,7 on consecutive cycles -> the cycle after the 4th beat: y=16'h735A, frame_valid=1 for 1 cycle, sync_err=0, locked=1, slot=0.
2. Non-sync beats 1,2 while in HUNT, then sync/9,4,2,8 -> first two beats dropped (locked stays 0); y=16'h824, 9 i.e. 16'h8249, with one frame_valid.
3. Locked with slot=2 (after sync/1,2), then beat sync/C followed by D,E,F -> sync_err pulse on the sync/C cycle; no frame_valid for the partial frame; then y=16'hFEDC with one frame_valid.
4. After a completed frame, non-sync beat 6 at slot 0 -> sync_err=1 for 1 cycle, locked=0, y unchanged, no frame_valid.
5. Frame sync/A,B, en=0 for 3 cycles with in_valid=1 and data F, then en=1 with C,D -> the F beats are ignored, slot holds at 2, y=16'hDCBA.
6. rst_n pulsed low asynchronously (between clock edges) during slot 2 of a frame -> outputs go to 0 immediately; subsequent non-sync beats are dropped until a sync arrives.
